// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle control unit: state codes, condition
// codes, datapath mux selects and the ALU command groupings.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADDR  = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWRITE = 4'd4,
        S_MEMWB    = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_SVC      = 4'd10,
        S_FAULT    = 4'd11
    } state_e;

    // Instruction classes
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_SVC = 2'b11;

    // Condition codes (1110 and 1111 both mean "always")
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;

    // result_src: registered ALU output, memory read data, live ALU result
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    // alu_src_b: register operand, extended immediate, constant four
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Every control output except state_o, in port order
    typedef struct packed {
        logic       mem_req;
        logic       mem_w;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_w;
        logic [1:0] result_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       alu_op;
        logic [1:0] flag_w;
        logic       link;
        logic       svc;
        logic       bus_error;
    } ctrl_t;

    // Compare/test commands (TST, TEQ, CMP, CMN) update flags only
    function automatic logic is_no_write(input logic [3:0] cmd);
        return cmd inside {4'b1000, 4'b1001, 4'b1010, 4'b1011};
    endfunction

    // Arithmetic commands produce meaningful carry and overflow
    function automatic logic is_cv_write(input logic [3:0] cmd);
        return cmd inside {4'b0100, 4'b0010, 4'b1010, 4'b1011, 4'b0101, 4'b0011};
    endfunction

endpackage

// File: rtl/cond_check.sv
// Evaluates an instruction condition field against the NZCV flags.
module cond_check
    import mc_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, c, v;
    assign {n, z, c, v} = flags;

    // Condition table lookup; 1110/1111 fall through to "always"
    always_comb begin
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c & !z;
            COND_LS: pass = !c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z & (n == v);
            COND_LE: pass = z | (n != v);
            default: pass = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle processor control FSM with memory-wait timeout and sticky bus fault.
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter bit SVC_EN  = 1'b1,
    parameter bit BL_EN   = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [3:0] rd,
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_w,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_w,
    output logic [1:0] result_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       alu_op,
    output logic [1:0] flag_w,
    output logic       link,
    output logic       svc,
    output logic       bus_error,
    output logic [3:0] state_o
);

    // Last wait count still allowed; one more idle cycle is a fault
    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       cond_pass;
    logic [3:0] cmd;
    ctrl_t      ctrl, ctrl_o;

    assign cmd = funct[4:1];

    cond_check u_cond_check (
        .cond  (cond),
        .flags (flags),
        .pass  (cond_pass)
    );

    // State and wait-counter registers, synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, wait counting and per-state control decode
    always_comb begin
        // NOTE: every output of this block is defaulted first so no path
        // through the case statement can leave a latch behind.
        ctrl    = '0;
        state_d = state_q;
        cnt_d   = '0;

        case (state_q)
            S_FETCH: begin
                ctrl.mem_req = 1'b1;
                if (mem_ready) begin
                    ctrl.ir_write   = 1'b1;
                    ctrl.pc_write   = 1'b1;
                    ctrl.alu_src_a  = 1'b1;
                    ctrl.alu_src_b  = SRCB_FOUR;
                    ctrl.result_src = RES_ALURES;
                    state_d         = S_DECODE;
                end else if (cnt_q == WAIT_LIMIT) begin
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            S_DECODE: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.result_src = RES_ALURES;
                if (!cond_pass) begin
                    state_d = S_FETCH;
                end else begin
                    case (op)
                        OP_MEM:  state_d = S_MEMADDR;
                        OP_DP:   state_d = funct[5] ? S_EXEC_I : S_EXEC_R;
                        OP_BR:   state_d = S_BRANCH;
                        default: state_d = SVC_EN ? S_SVC : S_FETCH;
                    endcase
                end
            end

            S_EXEC_R, S_EXEC_I: begin
                ctrl.alu_op    = 1'b1;
                ctrl.alu_src_b = (state_q == S_EXEC_I) ? SRCB_IMM : SRCB_REG;
                ctrl.flag_w    = {funct[0], funct[0] & is_cv_write(cmd)};
                state_d        = is_no_write(cmd) ? S_FETCH : S_ALUWB;
            end

            S_ALUWB: begin
                ctrl.reg_w      = 1'b1;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_write   = (rd == 4'd15);
                state_d         = S_FETCH;
            end

            S_MEMADDR: begin
                ctrl.alu_src_b = SRCB_IMM;
                state_d        = funct[0] ? S_MEMREAD : S_MEMWRITE;
            end

            S_MEMREAD: begin
                ctrl.mem_req = 1'b1;
                ctrl.adr_src = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else if (cnt_q == WAIT_LIMIT) begin
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            S_MEMWB: begin
                ctrl.reg_w      = 1'b1;
                ctrl.result_src = RES_DATA;
                state_d         = S_FETCH;
            end

            S_MEMWRITE: begin
                ctrl.mem_req = 1'b1;
                ctrl.mem_w   = 1'b1;
                ctrl.adr_src = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else if (cnt_q == WAIT_LIMIT) begin
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            S_BRANCH: begin
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.result_src = RES_ALURES;
                ctrl.pc_write   = 1'b1;
                ctrl.link       = BL_EN & funct[4];
                state_d         = S_FETCH;
            end

            S_SVC: begin
                ctrl.svc      = 1'b1;
                ctrl.pc_write = 1'b1;
                state_d       = S_FETCH;
            end

            S_FAULT: begin
                // Only reset leaves this state
                ctrl.bus_error = 1'b1;
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Reset forces every output low, including mem_req and the state code
    assign ctrl_o  = reset ? '0 : ctrl;
    assign state_o = reset ? 4'd0 : state_q;

    assign {mem_req, mem_w, adr_src, ir_write, pc_write, reg_w, result_src,
            alu_src_a, alu_src_b, alu_op, flag_w, link, svc, bus_error} = ctrl_o;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench: directed instructions, expected per-cycle outputs built
// from the instruction semantics, compared on every falling edge.
module tb_multicycle_ctrl;
    import mc_pkg::*;

    localparam int TB_TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] op = '0;
    logic [5:0] funct = '0;
    logic [3:0] rd = '0;
    logic [3:0] cond = '0;
    logic [3:0] flags = '0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_w, adr_src, ir_write, pc_write, reg_w;
    logic [1:0] result_src, alu_src_b, flag_w;
    logic       alu_src_a, alu_op, link, svc, bus_error;
    logic [3:0] state_o;

    always #5 clk = ~clk;

    multicycle_ctrl #(
        .TIMEOUT (TB_TIMEOUT),
        .SVC_EN  (1'b1),
        .BL_EN   (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .rd         (rd),
        .cond       (cond),
        .flags      (flags),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_w      (mem_w),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_w      (reg_w),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .flag_w     (flag_w),
        .link       (link),
        .svc        (svc),
        .bus_error  (bus_error),
        .state_o    (state_o)
    );

    typedef struct packed {
        logic       mem_req, mem_w, adr_src, ir_write, pc_write, reg_w;
        logic [1:0] result_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       alu_op;
        logic [1:0] flag_w;
        logic       link, svc, bus_error;
        logic [3:0] state_o;
    } exp_t;

    typedef struct packed {
        logic rst;
        logic mr;
        exp_t e;
    } step_t;

    step_t sq[$];
    exp_t  exp_cur;
    exp_t  dut_vec;
    bit    exp_valid = 1'b0;
    string cur_name = "";
    int    step_no = 0;
    int    tests_run = 0;
    int    tests_failed = 0;

    assign dut_vec = {mem_req, mem_w, adr_src, ir_write, pc_write, reg_w, result_src,
                      alu_src_a, alu_src_b, alu_op, flag_w, link, svc, bus_error, state_o};

    // Per-cycle comparison against the planned expectation
    always @(negedge clk) begin
        if (exp_valid) begin
            tests_run++;
            if (dut_vec !== exp_cur) begin
                tests_failed++;
                $display("FAIL %s step %0d: got %h expected %h", cur_name, step_no, dut_vec, exp_cur);
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", nm, got, want);
        end
    endtask

    // Condition evaluated as a base predicate per pair, odd codes inverting it
    function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
        bit n = f[3];
        bit z = f[2];
        bit cy = f[1];
        bit v = f[0];
        bit base;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: return 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    function automatic exp_t at(input state_e s);
        exp_t e = '0;
        e.state_o = s;
        return e;
    endfunction

    task automatic push(input logic rst, input logic mr, input exp_t e);
        step_t s;
        s.rst = rst;
        s.mr  = mr;
        s.e   = e;
        sq.push_back(s);
    endtask

    task automatic plan_fetch(input int waits);
        exp_t e = at(S_FETCH);
        e.mem_req = 1'b1;
        for (int i = 0; i < waits; i++) push(1'b0, 1'b0, e);
        e.ir_write   = 1'b1;
        e.pc_write   = 1'b1;
        e.alu_src_a  = 1'b1;
        e.alu_src_b  = 2'b10;
        e.result_src = 2'b10;
        push(1'b0, 1'b1, e);
    endtask

    // Whole instruction; cut stops after 'mw' unanswered memory cycles
    task automatic plan_instr(input logic [1:0] o, input logic [5:0] f, input logic [3:0] r,
                              input logic [3:0] c, input logic [3:0] fl,
                              input int fw, input int mw, input bit cut);
        exp_t       e;
        logic [3:0] k = f[4:1];
        plan_fetch(fw);
        e = at(S_DECODE);
        e.alu_src_a  = 1'b1;
        e.alu_src_b  = 2'b10;
        e.result_src = 2'b10;
        push(1'b0, 1'b1, e);
        if (!cond_holds(c, fl)) return;
        case (o)
            2'b01: begin
                e = at(S_MEMADDR);
                e.alu_src_b = 2'b01;
                push(1'b0, 1'b1, e);
                e = at(f[0] ? S_MEMREAD : S_MEMWRITE);
                e.mem_req = 1'b1;
                e.adr_src = 1'b1;
                e.mem_w   = !f[0];
                for (int i = 0; i < mw; i++) push(1'b0, 1'b0, e);
                if (cut) return;
                push(1'b0, 1'b1, e);
                if (f[0]) begin
                    e = at(S_MEMWB);
                    e.reg_w      = 1'b1;
                    e.result_src = 2'b01;
                    push(1'b0, 1'b1, e);
                end
            end
            2'b00: begin
                e = at(f[5] ? S_EXEC_I : S_EXEC_R);
                e.alu_op    = 1'b1;
                e.alu_src_b = f[5] ? 2'b01 : 2'b00;
                e.flag_w[1] = f[0];
                e.flag_w[0] = f[0] && ((k >= 4'd2 && k <= 4'd5) || k == 4'd10 || k == 4'd11);
                push(1'b0, 1'b1, e);
                if (k[3:2] != 2'b10) begin
                    e = at(S_ALUWB);
                    e.reg_w    = 1'b1;
                    e.pc_write = (r == 4'd15);
                    push(1'b0, 1'b1, e);
                end
            end
            2'b10: begin
                e = at(S_BRANCH);
                e.alu_src_b  = 2'b01;
                e.result_src = 2'b10;
                e.pc_write   = 1'b1;
                e.link       = f[4];
                push(1'b0, 1'b1, e);
            end
            default: begin
                e = at(S_SVC);
                e.svc      = 1'b1;
                e.pc_write = 1'b1;
                push(1'b0, 1'b1, e);
            end
        endcase
    endtask

    // Fetch that never completes, then a few cycles in the fault state
    task automatic plan_fault_run(input int fault_cycles);
        exp_t e = at(S_FETCH);
        e.mem_req = 1'b1;
        for (int i = 0; i < TB_TIMEOUT; i++) push(1'b0, 1'b0, e);
        e = at(S_FAULT);
        e.bus_error = 1'b1;
        for (int i = 0; i < fault_cycles; i++) push(1'b0, i[0], e);
    endtask

    task automatic plan_reset();
        push(1'b1, 1'b1, '0);
    endtask

    task automatic run_plan(input string nm);
        cur_name = nm;
        for (int i = 0; i < sq.size(); i++) begin
            reset     = sq[i].rst;
            mem_ready = sq[i].mr;
            exp_cur   = sq[i].e;
            step_no   = i;
            exp_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        exp_valid = 1'b0;
        sq.delete();
    endtask

    task automatic do_instr(input string nm, input logic [1:0] o, input logic [5:0] f,
                            input logic [3:0] r, input logic [3:0] c, input logic [3:0] fl,
                            input int fw, input int mw, input int exp_len);
        op = o; funct = f; rd = r; cond = c; flags = fl;
        plan_instr(o, f, r, c, fl, fw, mw, 1'b0);
        check({nm, " length"}, sq.size(), exp_len);
        run_plan(nm);
    endtask

    initial begin
        @(posedge clk);
        #1;
        plan_reset();
        plan_reset();
        run_plan("reset");

        do_instr("add",           2'b00, 6'b001001, 4'd3,  4'b1110, 4'b0000, 0, 0, 4);
        do_instr("ldr wait",      2'b01, 6'b011001, 4'd2,  4'b1110, 4'b0000, 1, 3, 9);
        do_instr("beq not taken", 2'b10, 6'b000000, 4'd0,  4'b0000, 4'b0000, 0, 0, 2);
        do_instr("beq taken",     2'b10, 6'b000000, 4'd0,  4'b0000, 4'b0100, 0, 0, 3);
        do_instr("cmp",           2'b00, 6'b010101, 4'd0,  4'b1110, 4'b0000, 0, 0, 3);
        do_instr("bl",            2'b10, 6'b110000, 4'd14, 4'b1110, 4'b0000, 0, 0, 3);
        do_instr("addi to pc",    2'b00, 6'b101000, 4'd15, 4'b1110, 4'b0000, 0, 0, 4);
        do_instr("str",           2'b01, 6'b011000, 4'd4,  4'b1110, 4'b0000, 0, 2, 6);
        do_instr("svc",           2'b11, 6'b000000, 4'd0,  4'b1111, 4'b0000, 0, 0, 3);
        do_instr("subs ge",       2'b00, 6'b000101, 4'd5,  4'b1010, 4'b1001, 0, 0, 4);
        do_instr("mov gt fails",  2'b00, 6'b011010, 4'd6,  4'b1100, 4'b0100, 0, 0, 2);
        do_instr("bhi taken",     2'b10, 6'b000000, 4'd0,  4'b1000, 4'b0010, 0, 0, 3);
        do_instr("bls not taken", 2'b10, 6'b000000, 4'd0,  4'b1001, 4'b0010, 0, 0, 2);
        do_instr("tst mi",        2'b00, 6'b010001, 4'd7,  4'b0100, 4'b1000, 0, 0, 3);
        do_instr("bvc not taken", 2'b10, 6'b000000, 4'd0,  4'b0111, 4'b0001, 0, 0, 2);
        do_instr("ldr last wait", 2'b01, 6'b011001, 4'd2,  4'b1110, 4'b0000,
                 TB_TIMEOUT - 1, TB_TIMEOUT - 1, 33);

        // Fetch timeout into a sticky fault, then recovery through reset
        plan_fault_run(3);
        check("fetch timeout length", sq.size(), 18);
        run_plan("fetch timeout");
        check("bus_error sticky", bus_error, 1);
        check("fault state code", state_o, S_FAULT);
        plan_reset();
        run_plan("reset from fault");
        check("bus_error cleared", bus_error, 0);
        do_instr("add after fault", 2'b00, 6'b001001, 4'd3, 4'b1110, 4'b0000, 0, 0, 4);

        // Reset during a stalled store; a full-length timeout afterwards
        // shows the wait count restarted from zero
        op = 2'b01; funct = 6'b011000; rd = 4'd1; cond = 4'b1110; flags = 4'b0000;
        plan_instr(2'b01, 6'b011000, 4'd1, 4'b1110, 4'b0000, 0, 2, 1'b1);
        plan_reset();
        plan_fault_run(2);
        plan_reset();
        check("reset mid-write length", sq.size(), 24);
        run_plan("reset mid-write");

        do_instr("final add", 2'b00, 6'b001001, 4'd3, 4'b1110, 4'b0000, 0, 0, 4);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
